hvac_drive_ctrl: RTL and testbench

// - Plant-side counterpart to the thermostat: consumes setpoint (DesiredTemp) and sensed temp
//   (CurrentTemp, both 0..99 binary) and drives heat/cool/fan outputs to the HVAC relays.
// - Applies hysteresis, minimum run / minimum off times and sensor-fault lockout.
// - Sits between the thermostat controller and the relay pins; paced by a slow tick enable, no derived clocks.

---
 rtl/thermostat_pkg.sv | 24 ++
 rtl/hvac_tick_timer.sv | 25 ++
 rtl/hvac_drive_ctrl.sv | 119 +++++++++++
 tb/tb_hvac_drive_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/thermostat_pkg.sv
// rtl/thermostat_pkg.sv - shared state/mode encodings and temperature limits for the HVAC drive
package thermostat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAT    = 2'd1,
        ST_COOL    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_OFF       = 2'd0,
        MODE_HEAT_ONLY = 2'd1,
        MODE_COOL_ONLY = 2'd2,
        MODE_AUTO      = 2'd3
    } mode_t;

    localparam logic [7:0] TEMP_MAX = 8'd99;

    function automatic logic temp_invalid(input logic [7:0] t);
        return t > TEMP_MAX;
    endfunction

endpackage

// File: rtl/hvac_tick_timer.sv
// rtl/hvac_tick_timer.sv - loadable, tick-enabled, saturating down-counter
module hvac_tick_timer #(
    parameter int CNT_W   = 16,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count
);

    // A load on the same clk as a tick wins over the decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= CNT_W'(RST_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/hvac_drive_ctrl.sv
// rtl/hvac_drive_ctrl.sv - HVAC relay FSM with hysteresis, min run/off and fault lockout; HVAC_FAN_OVERRUN_EN adds fan overrun
module hvac_drive_ctrl
    import thermostat_pkg::*;
#(
    parameter int HYST    = 2,
    parameter int MIN_ON  = 30,
    parameter int MIN_OFF = 60,
    parameter int FAN_RUN = 20,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [1:0] mode,
    input  logic [7:0] DesiredTemp,
    input  logic [7:0] CurrentTemp,
    output logic       heat_on,
    output logic       cool_on,
    output logic       fan_on,
    output logic       fault,
    output logic [1:0] state_o
);

    state_t           state;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_val;
    logic             run_load;
    logic [8:0]       cur9;
    logic [8:0]       des9;
    logic             need_heat, need_cool, temp_bad, fault_now;
    logic             heat_ok, cool_ok, expiring;
    logic             exit_heat, exit_cool, start_heat, start_cool, leave_lock;

    assign cur9      = {1'b0, CurrentTemp};
    assign des9      = {1'b0, DesiredTemp};
    assign need_heat = (cur9 + 9'(HYST)) < des9;
    assign need_cool = cur9 > (des9 + 9'(HYST));
    assign temp_bad  = temp_invalid(CurrentTemp) || temp_invalid(DesiredTemp);
    assign fault_now = fault || temp_bad;
    assign heat_ok   = (mode == MODE_HEAT_ONLY) || (mode == MODE_AUTO);
    assign cool_ok   = (mode == MODE_COOL_ONLY) || (mode == MODE_AUTO);

    // The tick that runs the timer out is the tick that acts on it, so a
    // load of N means exactly N ticks are spent in the state.
    assign expiring   = run_cnt <= CNT_W'(1);

    assign exit_heat  = (state == ST_HEAT) && (!heat_ok || ((cur9 >= des9) && expiring));
    assign exit_cool  = (state == ST_COOL) && (!cool_ok || ((cur9 <= des9) && expiring));
    assign start_heat = (state == ST_IDLE) && need_heat && heat_ok;
    assign start_cool = (state == ST_IDLE) && !start_heat && need_cool && cool_ok;
    assign leave_lock = (state == ST_LOCKOUT) && expiring;

    assign run_load = fault_now || (tick && (exit_heat || exit_cool || start_heat || start_cool));
    assign run_val  = (start_heat || start_cool) && !fault_now ? CNT_W'(MIN_ON) : CNT_W'(MIN_OFF);

    hvac_tick_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (MIN_OFF)
    ) u_run_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .load     (run_load),
        .load_val (run_val),
        .count    (run_cnt)
    );

    // Fault acts on every clk, not just on ticks, and pins the FSM in LOCKOUT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_LOCKOUT;
            fault <= 1'b0;
        end else begin
            if (temp_bad) begin
                fault <= 1'b1;
            end
            if (fault_now) begin
                state <= ST_LOCKOUT;
            end else if (tick) begin
                if (exit_heat || exit_cool) begin
                    state <= ST_LOCKOUT;
                end else if (start_heat) begin
                    state <= ST_HEAT;
                end else if (start_cool) begin
                    state <= ST_COOL;
                end else if (leave_lock) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    assign heat_on = (state == ST_HEAT);
    assign cool_on = (state == ST_COOL);
    assign state_o = state;

`ifdef HVAC_FAN_OVERRUN_EN
    logic [CNT_W-1:0] ovr_cnt;

    hvac_tick_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (0)
    ) u_fan_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .load     (fault_now || (tick && (exit_heat || exit_cool))),
        .load_val (fault_now ? '0 : CNT_W'(FAN_RUN)),
        .count    (ovr_cnt)
    );

    assign fan_on = heat_on || cool_on || (ovr_cnt != '0);
`else
    logic unused_fan_run;
    assign unused_fan_run = ^FAN_RUN;
    assign fan_on         = heat_on || cool_on;
`endif

endmodule

// File: tb/tb_hvac_drive_ctrl.sv
// tb/tb_hvac_drive_ctrl.sv - directed scoreboard bench for hvac_drive_ctrl
module tb_hvac_drive_ctrl;

`ifdef HVAC_FAN_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0, S_HEAT = 2'd1, S_COOL = 2'd2, S_LOCK = 2'd3;
    localparam logic [1:0] M_OFF = 2'd0, M_HEAT = 2'd1, M_AUTO = 2'd3;

    typedef struct {
        string      tag;
        logic [5:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] tcnt = 2'd0;
    logic [1:0] mode = M_AUTO;
    logic [7:0] des = 8'd70;
    logic [7:0] cur = 8'd70;
    logic       heat_on, cool_on, fan_on, fault;
    logic [1:0] state_o;

    exp_t q[$];
    int   asserts = 0;
    int   failures = 0;

    hvac_drive_ctrl #(
        .HYST    (2),
        .MIN_ON  (3),
        .MIN_OFF (4),
        .FAN_RUN (2),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .mode        (mode),
        .DesiredTemp (des),
        .CurrentTemp (cur),
        .heat_on     (heat_on),
        .cool_on     (cool_on),
        .fan_on      (fan_on),
        .fault       (fault),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // tick is one clk wide every fourth clk, changed only on negedges
    always @(negedge clk) begin
        tcnt = tcnt + 2'd1;
        tick = (tcnt == 2'd3);
    end

    task automatic push(input string tag, input logic [1:0] st, input bit h, input bit c,
                        input bit f, input bit flt);
        exp_t e;
        e.tag = tag;
        e.val = {st, h, c, f, flt};
        q.push_back(e);
    endtask

    task automatic check_now();
        exp_t       e;
        logic [5:0] obs;
        e   = q.pop_front();
        obs = {state_o, heat_on, cool_on, fan_on, fault};
        asserts++;
        assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed {st,h,c,f,flt}=%b expected %b", e.tag, obs, e.val);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        @(posedge clk);
        while (tick !== 1'b1 && n < 8) begin
            @(posedge clk);
            n++;
        end
        if (tick !== 1'b1) begin
            failures++;
            $error("FAIL tick_timeout observed no tick within %0d clks expected one", n);
        end
        #1;
    endtask

    task automatic step(input string tag, input logic [1:0] st, input bit h, input bit c,
                        input bit f, input bit flt);
        push(tag, st, h, c, f, flt);
        wait_tick();
        check_now();
    endtask

    initial begin
        #3 reset_n = 1'b0;
        #1;
        push("reset", S_LOCK, 0, 0, 0, 0);
        check_now();
        @(negedge clk) reset_n = 1'b1;

        step("lock_t1", S_LOCK, 0, 0, 0, 0);
        step("lock_t2", S_LOCK, 0, 0, 0, 0);
        step("lock_t3", S_LOCK, 0, 0, 0, 0);
        step("lock_to_idle", S_IDLE, 0, 0, 0, 0);

        cur = 8'd67;
        step("heat_enter", S_HEAT, 1, 0, 1, 0);
        cur = 8'd70;
        step("heat_min_on1", S_HEAT, 1, 0, 1, 0);
        step("heat_min_on2", S_HEAT, 1, 0, 1, 0);
        step("heat_exit", S_LOCK, 0, 0, OVR, 0);
        cur = 8'd72;
        step("heat_ovr1", S_LOCK, 0, 0, OVR, 0);
        step("heat_ovr_end", S_LOCK, 0, 0, 0, 0);
        step("lock2_t3", S_LOCK, 0, 0, 0, 0);
        step("lock2_idle", S_IDLE, 0, 0, 0, 0);

        step("deadband_72", S_IDLE, 0, 0, 0, 0);
        mode = M_HEAT;
        cur  = 8'd80;
        step("heat_only_no_cool", S_IDLE, 0, 0, 0, 0);
        mode = M_AUTO;
        cur  = 8'd73;
        step("cool_enter", S_COOL, 0, 1, 1, 0);

        mode = M_OFF;
        step("mode_off_exit", S_LOCK, 0, 0, OVR, 0);
        step("off_lock_t1", S_LOCK, 0, 0, OVR, 0);
        step("off_lock_t2", S_LOCK, 0, 0, 0, 0);
        step("off_lock_t3", S_LOCK, 0, 0, 0, 0);
        step("off_lock_idle", S_IDLE, 0, 0, 0, 0);
        step("off_idle_hold", S_IDLE, 0, 0, 0, 0);

        mode = M_AUTO;
        cur  = 8'd67;
        step("heat_again", S_HEAT, 1, 0, 1, 0);
        cur = 8'd120;
        push("fault_set", S_LOCK, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        check_now();
        cur = 8'd70;
        for (int i = 0; i < 6; i++) begin
            step("fault_held", S_LOCK, 0, 0, 0, 1);
        end

        #2 reset_n = 1'b0;
        #1;
        push("fault_reset", S_LOCK, 0, 0, 0, 0);
        check_now();
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_tick();
        end
        step("post_reset_idle", S_IDLE, 0, 0, 0, 0);
        cur = 8'd67;
        step("heat_pre_async", S_HEAT, 1, 0, 1, 0);
        #2 reset_n = 1'b0;
        #1;
        push("async_reset", S_LOCK, 0, 0, 0, 0);
        check_now();
        @(negedge clk) reset_n = 1'b1;

        des = 8'd99;
        cur = 8'd99;
        push("temp99_ok", S_LOCK, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_now();
        des = 8'd100;
        push("des100_fault", S_LOCK, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        check_now();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
